// File: rtl/spi_apb_arbiter.sv
// -----------------------------------------------------------------------------
// spi_apb_arbiter
//
// Shares one APB-attached SPI master between two requesters. Each requester
// posts a 32-bit word and a target slave select. The arbiter picks a winner
// round-robin and runs one APB write followed by one APB read. It then returns
// the received word together with a one-cycle done pulse. If an APB access
// phase waits TIMEOUT cycles without PREADY, the transaction is aborted: done
// and err pulse together and rdata is forced to zero.
//
// Ports
//   PCLK, PRESET      clock; synchronous active-high reset
//   req0/req1         transfer request, held until the matching done pulse
//   tgt0/tgt1         target slave (0 = ss0, 1 = ss1)
//   wdata0/wdata1     transmit word
//   gnt0/gnt1         requester currently owns the SPI master
//   done0/done1       one-cycle completion pulse
//   rdata             received word, valid while a done pulse is high
//   err               one-cycle timeout pulse, coincident with done
//   PSEL..PWDATA      APB master request side
//   PREADY, PRDATA    APB master response side
//
// All outputs are registered. They are decoded from the next state, so each
// output lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module spi_apb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0,
    input  logic        req1,
    input  logic        tgt0,
    input  logic        tgt1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [2:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic [31:0] PRDATA
);

    // The counter only needs to reach TIMEOUT-1: the edge that would take it
    // to TIMEOUT is the timeout edge itself.
    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_ACCESS,
        RD_SETUP,
        RD_ACCESS,
        DONE
    } state_t;

    state_t            r_state;
    logic              r_owner;      // 0 = requester 0, 1 = requester 1
    logic              r_tgt;
    logic [31:0]       r_wdata;
    logic              r_rr_last;    // requester served last; reset value favours req0
    logic [CntW-1:0]   r_wait_cnt;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [2:0]        r_paddr;
    logic [31:0]       r_pwdata;

    state_t            w_state_nxt;
    logic              w_owner_nxt;
    logic              w_tgt_nxt;
    logic [31:0]       w_wdata_nxt;
    logic              w_rr_last_nxt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic [31:0]       w_rdata_nxt;
    logic              w_err_nxt;
    logic              w_win;
    logic              w_timeout;
    logic              w_busy;

    // With both requests pending, the requester not served last wins.
    assign w_win     = (req0 && req1) ? ~r_rr_last : req1;
    assign w_timeout = (r_wait_cnt == CntLast);

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_tgt_nxt     = r_tgt;
        w_wdata_nxt   = r_wdata;
        w_rr_last_nxt = r_rr_last;
        w_cnt_nxt     = r_wait_cnt;
        w_rdata_nxt   = r_rdata;
        w_err_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_owner_nxt = w_win;
                    w_tgt_nxt   = w_win ? tgt1 : tgt0;
                    w_wdata_nxt = w_win ? wdata1 : wdata0;
                    w_state_nxt = WR_SETUP;
                end
            end
            WR_SETUP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WR_ACCESS;
            end
            WR_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt = RD_SETUP;
                end else if (w_timeout) begin
                    // Abort skips the read phase entirely.
                    w_rdata_nxt = 32'h0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            RD_SETUP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = RD_ACCESS;
            end
            RD_ACCESS: begin
                if (PREADY) begin
                    w_rdata_nxt = PRDATA;
                    w_state_nxt = DONE;
                end else if (w_timeout) begin
                    w_rdata_nxt = 32'h0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            DONE: begin
                w_rr_last_nxt = r_owner;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_busy = (w_state_nxt != IDLE);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_tgt      <= 1'b0;
            r_wdata    <= 32'h0;
            r_rr_last  <= 1'b1;
            r_wait_cnt <= '0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= 3'b000;
            r_pwdata   <= 32'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_tgt      <= w_tgt_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rr_last  <= w_rr_last_nxt;
            r_wait_cnt <= w_cnt_nxt;
            r_rdata    <= w_rdata_nxt;
            r_err      <= w_err_nxt;
            r_gnt0     <= w_busy && !w_owner_nxt;
            r_gnt1     <= w_busy && w_owner_nxt;
            r_done0    <= (w_state_nxt == DONE) && !w_owner_nxt;
            r_done1    <= (w_state_nxt == DONE) && w_owner_nxt;
            r_psel     <= w_busy && (w_state_nxt != DONE);
            r_penable  <= (w_state_nxt == WR_ACCESS) || (w_state_nxt == RD_ACCESS);
            r_pwrite   <= (w_state_nxt == WR_SETUP) || (w_state_nxt == WR_ACCESS);
            r_paddr    <= w_busy ? (w_tgt_nxt ? 3'b010 : 3'b100) : 3'b000;
            r_pwdata   <= w_busy ? w_wdata_nxt : 32'h0;
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign rdata   = r_rdata;
    assign err     = r_err;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_apb_arbiter
//
// Directed bench for spi_apb_arbiter with a response scoreboard. Each test
// pushes its expected {owner, rdata, err}. A monitor pops one entry on every
// done pulse and compares it. The main sequence checks APB phase timing,
// addressing, grant order and reset behaviour. An APB slave model drives
// PREADY: tied high, delayed by a fixed wait count, or stuck low.
// -----------------------------------------------------------------------------
module tb_spi_apb_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req0, req1, tgt0, tgt1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err;
    logic [31:0] rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [2:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PREADY = 1'b0;
    logic [31:0] PRDATA;

    spi_apb_arbiter #(.TIMEOUT(255)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .req0    (req0),
        .req1    (req1),
        .tgt0    (tgt0),
        .tgt1    (tgt1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .rdata   (rdata),
        .err     (err),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    function automatic exp_t mk_exp(input logic owner, input logic [31:0] rd, input logic e);
        exp_t x;
        x.owner = owner;
        x.rdata = rd;
        x.err   = e;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // APB slave model: 0 = PREADY tied high, 1 = ready after pready_delay
    // wait cycles in each access phase, 2 = PREADY stuck low.
    int pready_mode  = 0;
    int pready_delay = 80;
    int acc_cnt      = 0;

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            case (pready_mode)
                0:       PREADY = 1'b1;
                1:       PREADY = (acc_cnt >= pready_delay);
                default: PREADY = 1'b0;
            endcase
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY  = (pready_mode == 0);
        end
    end

    // Scoreboard monitor.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (done0 || done1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'({done1, done0}), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_done_owner", 32'({done1, done0}), mon_e.owner ? 32'd2 : 32'd1);
                    check("sb_rdata", rdata, mon_e.rdata);
                    check("sb_err", 32'(err), 32'(mon_e.err));
                end
            end else if (err) begin
                check("err_without_done", 32'(err), 32'd0);
            end
        end
    end

    // Runs one transaction from the negedge after its request became visible.
    // Cycle 1 is the cycle after the edge that samples the request.
    task automatic run_txn(input int budget, output int done_cyc, output int en_cyc,
                           output int wr_en_cyc, output logic [14:0] trace,
                           output logic [1:0] gnt1st, output logic [2:0] paddr1,
                           output logic [31:0] pwdata1, output int paddr_bad);
        done_cyc  = -1;
        en_cyc    = 0;
        wr_en_cyc = 0;
        trace     = '0;
        gnt1st    = '0;
        paddr1    = '0;
        pwdata1   = '0;
        paddr_bad = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                gnt1st  = {gnt1, gnt0};
                paddr1  = PADDR;
                pwdata1 = PWDATA;
            end
            if (c <= 5) trace[3*(c-1) +: 3] = {PSEL, PENABLE, PWRITE};
            if (PADDR != paddr1) paddr_bad++;
            if (PENABLE) en_cyc++;
            if (PENABLE && PWRITE) wr_en_cyc++;
            if (done0 || done1) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"},    32'(gnt0),    32'd0);
        check({tag, "_gnt1"},    32'(gnt1),    32'd0);
        check({tag, "_done0"},   32'(done0),   32'd0);
        check({tag, "_done1"},   32'(done1),   32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
        check({tag, "_rdata"},   rdata,        32'd0);
        check({tag, "_psel"},    32'(PSEL),    32'd0);
        check({tag, "_penable"}, 32'(PENABLE), 32'd0);
        check({tag, "_pwrite"},  32'(PWRITE),  32'd0);
        check({tag, "_paddr"},   32'(PADDR),   32'd0);
        check({tag, "_pwdata"},  PWDATA,       32'd0);
    endtask

    int          dc, en, wen, pbad, dn;
    logic [14:0] tr;
    logic [1:0]  g;
    logic [2:0]  pa;
    logic [31:0] pw;

    initial begin
        PRESET = 1'b1;
        req0 = 1'b0; req1 = 1'b0; tgt0 = 1'b0; tgt1 = 1'b0;
        wdata0 = 32'h0; wdata1 = 32'h0; PRDATA = 32'h0;
        repeat (3) @(negedge PCLK);
        check_all_zero("reset");
        PRESET = 1'b0;
        @(negedge PCLK);

        // Zero-wait transfer to ss0.
        pready_mode = 0;
        PRDATA = 32'h5555_5555;
        tgt0 = 1'b0; wdata0 = 32'hAAAA_FAEB; req0 = 1'b1;
        sb_q.push_back(mk_exp(1'b0, 32'h5555_5555, 1'b0));
        run_txn(20, dc, en, wen, tr, g, pa, pw, pbad);
        req0 = 1'b0;
        check("t1_done_cycle", dc, 32'd5);
        check("t1_phase_trace", 32'(tr), 32'({3'b000, 3'b110, 3'b100, 3'b111, 3'b101}));
        check("t1_gnt", 32'(g), 32'b01);
        check("t1_paddr", 32'(pa), 32'b100);
        check("t1_pwdata", pw, 32'hAAAA_FAEB);
        check("t1_paddr_stable", pbad, 32'd0);
        repeat (2) @(negedge PCLK);

        // 80 wait cycles in each access phase, ss1.
        pready_mode = 1; pready_delay = 80;
        PRDATA = 32'h1234_5678;
        tgt1 = 1'b1; wdata1 = 32'hF0F0_F0F0; req1 = 1'b1;
        sb_q.push_back(mk_exp(1'b1, 32'h1234_5678, 1'b0));
        run_txn(400, dc, en, wen, tr, g, pa, pw, pbad);
        req1 = 1'b0;
        check("t2_done_cycle", dc, 32'd165);
        check("t2_penable_cycles", en, 32'd162);
        check("t2_write_access_cycles", wen, 32'd81);
        check("t2_gnt", 32'(g), 32'b10);
        check("t2_paddr", 32'(pa), 32'b010);
        check("t2_pwdata", pw, 32'hF0F0_F0F0);
        check("t2_paddr_stable", pbad, 32'd0);
        repeat (2) @(negedge PCLK);

        // Both requesting for three transactions: order 0, 1, 0.
        pready_mode = 0;
        PRDATA = 32'hC0DE_0003;
        tgt0 = 1'b0; tgt1 = 1'b1;
        wdata0 = 32'h0101_0101; wdata1 = 32'h0202_0202;
        sb_q.push_back(mk_exp(1'b0, 32'hC0DE_0003, 1'b0));
        sb_q.push_back(mk_exp(1'b1, 32'hC0DE_0003, 1'b0));
        sb_q.push_back(mk_exp(1'b0, 32'hC0DE_0003, 1'b0));
        req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            if (t > 0) begin
                @(negedge PCLK);
                check("t3_idle_gap_gnt", 32'({gnt1, gnt0}), 32'd0);
                check("t3_idle_gap_psel", 32'(PSEL), 32'd0);
            end
            run_txn(20, dc, en, wen, tr, g, pa, pw, pbad);
            check("t3_done_cycle", dc, 32'd5);
            check("t3_gnt_order", 32'(g), (t == 1) ? 32'b10 : 32'b01);
            check("t3_paddr", 32'(pa), (t == 1) ? 32'b010 : 32'b100);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge PCLK);

        // Reset during WR_ACCESS: everything clears, no done.
        pready_mode = 1; pready_delay = 80;
        tgt0 = 1'b1; wdata0 = 32'hDEAD_BEEF; req0 = 1'b1;
        repeat (2) @(negedge PCLK);
        check("t5_in_wr_access", 32'({PSEL, PENABLE, PWRITE}), 32'b111);
        @(negedge PCLK);
        PRESET = 1'b1; req0 = 1'b0;
        @(negedge PCLK);
        check_all_zero("t5_reset");
        PRESET = 1'b0;
        dn = 0;
        repeat (10) begin
            @(negedge PCLK);
            if (done0 || done1 || err || PSEL) dn++;
        end
        check("t5_no_activity_after_reset", dn, 32'd0);

        // Normal transfer after reset, so rdata is non-zero before the timeout test.
        pready_mode = 0;
        PRDATA = 32'h600D_F00D;
        tgt1 = 1'b1; wdata1 = 32'h1357_9BDF; req1 = 1'b1;
        sb_q.push_back(mk_exp(1'b1, 32'h600D_F00D, 1'b0));
        run_txn(20, dc, en, wen, tr, g, pa, pw, pbad);
        req1 = 1'b0;
        check("t6_done_cycle", dc, 32'd5);
        check("t6_gnt", 32'(g), 32'b10);
        repeat (2) @(negedge PCLK);

        // PREADY stuck low: 255 wait cycles, then done0 + err with rdata 0.
        pready_mode = 2;
        tgt0 = 1'b0; wdata0 = 32'h0BAD_0BAD; req0 = 1'b1;
        sb_q.push_back(mk_exp(1'b0, 32'h0, 1'b1));
        run_txn(600, dc, en, wen, tr, g, pa, pw, pbad);
        req0 = 1'b0;
        check("t4_done_cycle", dc, 32'd257);
        check("t4_wait_cycles", en, 32'd255);
        check("t4_write_access_cycles", wen, 32'd255);
        check("t4_gnt", 32'(g), 32'b01);
        check("t4_paddr", 32'(pa), 32'b100);
        repeat (3) @(negedge PCLK);
        check("t4_rdata_held", rdata, 32'h0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/spi_apb_arbiter.md
SPI_APB_ARBITER -- requirements
Module: spi_apb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of PCLK cycles spent waiting for PREADY in one APB access phase.
REQ-002 SHALL have port PCLK, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port PRESET, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports req0/req1, input, 1 each: requester transfer request, held high until the matching done pulse.
REQ-005 SHALL have ports tgt0/tgt1, input, 1 each: requester target slave (0 = ss0, 1 = ss1).
REQ-006 SHALL have ports wdata0/wdata1, input, 32 each: requester transmit word.
REQ-007 SHALL have ports gnt0/gnt1, output, 1 each: requester owns the SPI master.
REQ-008 SHALL have ports done0/done1, output, 1 each: one-cycle completion pulse.
REQ-009 SHALL have port rdata, output, 32: received word, valid while any done is high.
REQ-010 SHALL have port err, output, 1: one-cycle pulse, coincident with done, on timeout abort.
REQ-011 SHALL have APB master ports PSEL, PENABLE and PWRITE (output, 1 each), PADDR (output, 3) and PWDATA (output, 32), driving the SPI master's APB slave.
REQ-012 SHALL have APB master ports PREADY (input, 1) and PRDATA (input, 32), driven by the SPI master's APB slave.

Function
REQ-013 SHALL implement FSM states IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, DONE; all outputs registered.
REQ-014 SHALL, in IDLE with any req high, pick a winner and latch its tgt and wdata, then enter WR_SETUP on the next edge.
REQ-015 SHALL arbitrate round-robin: a single request wins outright; with both high, the requester not served last wins; after reset the pointer favours req0.
REQ-016 SHALL hold the winner's gnt high from WR_SETUP through DONE inclusive; the other gnt stays 0.
REQ-017 SHALL set PADDR to 3'b100 for target ss0 and 3'b010 for target ss1, held constant for the whole transaction.
REQ-018 SHALL, in WR_SETUP, drive PSEL=1, PENABLE=0, PWRITE=1 and PWDATA=latched word.
REQ-019 SHALL, in WR_ACCESS, drive PSEL=1, PENABLE=1, PWRITE=1, and leave the state on the first edge where PREADY=1.
REQ-020 SHALL, in RD_SETUP, drive PSEL=1, PENABLE=0, PWRITE=0.
REQ-021 SHALL, in RD_ACCESS, drive PSEL=1, PENABLE=1, PWRITE=0, and on the first edge with PREADY=1 capture PRDATA into rdata.
REQ-022 SHALL, in DONE, drive PSEL=0 and PENABLE=0, pulse the winner's done for one cycle, update the round-robin pointer, and return to IDLE.
REQ-023 SHALL, with zero-wait PREADY, assert done exactly 5 cycles after the edge that samples req in IDLE.
REQ-024 SHALL spend at least one IDLE cycle between transactions, with no grant in that cycle.
REQ-025 SHALL count wait cycles in each ACCESS state, clearing the count on entry.
REQ-026 SHALL, when the wait count reaches TIMEOUT without PREADY, go to DONE with rdata=32'h0 and pulse err together with done.
REQ-027 SHALL ignore req deassertion mid-transaction: the transfer completes and done still pulses.
REQ-028 SHALL hold rdata stable from DONE until the next capture or reset.

Reset
REQ-029 SHALL, while PRESET=1 at an edge, enter IDLE and clear all outputs (gnt, done, err, rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA) to 0, clear the wait counter, and point round-robin at req0.
REQ-030 SHALL abort any transaction immediately on reset mid-operation, with no done or err pulse.

Verification
REQ-031 SHALL cover: req0=1, tgt0=0, wdata0=32'hAAAAFAEB, PREADY tied 1, PRDATA=32'h55555555 -> PADDR=3'b100, write then read phase, done0 on cycle 5, rdata=32'h55555555.
REQ-032 SHALL cover: req1=1, tgt1=1, wdata1=32'hF0F0F0F0, PREADY delayed 80 cycles in each phase -> PADDR=3'b010, PENABLE held through the waits, done1 only after the second PREADY.
REQ-033 SHALL cover: req0 and req1 high together for three transactions -> grant order 0, 1, 0, with one IDLE cycle between them.
REQ-034 SHALL cover: TIMEOUT=255, PREADY stuck 0 -> exit after 255 wait cycles, err and done0 pulse together, rdata=0.
REQ-035 SHALL cover: PRESET=1 during WR_ACCESS -> next cycle all outputs 0, state IDLE, no done pulse.
